// File: rtl/wb_slave_mem_if.sv
// Wishbone classic bus bundle between a master and the wb_slave_mem slave.
// Signal names keep their slave-side direction prefixes (i_ = into slave).
interface wb_slave_mem_if #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 30
);
   localparam int SWIDTH = DWIDTH / 8;

   logic              i_wb_cyc;
   logic              i_wb_stb;
   logic              i_wb_we;
   logic [SWIDTH-1:0] i_wb_sel;
   logic [AWIDTH-1:0] i_wb_adr;
   logic [DWIDTH-1:0] i_wb_dat;
   logic [DWIDTH-1:0] o_wb_dat;
   logic              o_wb_ack;
   logic              o_wb_err;

   modport master (
      output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
      input  o_wb_dat, o_wb_ack, o_wb_err
   );

   modport slave (
      input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_sel, i_wb_adr, i_wb_dat,
      output o_wb_dat, o_wb_ack, o_wb_err
   );
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone classic slave backed by a word-addressed memory array.
// Independent read/write wait states, byte-lane writes, error termination
// for out-of-range addresses, and silent abort when the strobe drops
// while waiting.
module wb_slave_mem #(
   parameter int DWIDTH  = 32,
   parameter int AWIDTH  = 30,
   parameter int DEPTH   = 1024,
   parameter int RD_WAIT = 1,
   parameter int WR_WAIT = 0
) (
   input logic           i_ck,
   input logic           i_rb,
   wb_slave_mem_if.slave bus
);
   localparam int SWIDTH = DWIDTH / 8;
   localparam int IWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra bit so DEPTH == 2**AWIDTH still compares correctly.
   localparam logic [AWIDTH:0] DEPTH_L = (AWIDTH + 1)'(DEPTH);
   localparam logic [3:0]      RD_N    = 4'(RD_WAIT);
   localparam logic [3:0]      WR_N    = 4'(WR_WAIT);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [DWIDTH-1:0] dat_q;
   logic [DWIDTH-1:0] mem [DEPTH];

   logic              req;
   logic              oob;
   logic              to_resp;
   logic              wr_en;
   logic              rd_en;
   logic [3:0]        n_wait;
   logic [IWIDTH-1:0] idx;

   // Decode the master's current request: wait count, range check, index.
   always_comb begin
      req    = bus.i_wb_cyc & bus.i_wb_stb;
      n_wait = bus.i_wb_we ? WR_N : RD_N;
      oob    = ({1'b0, bus.i_wb_adr} >= DEPTH_L);
      idx    = bus.i_wb_adr[IWIDTH-1:0];
   end

   // Next-state logic; entering RESP is the single commit point of a transfer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      to_resp = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               if (n_wait == 4'd0) begin
                  to_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = n_wait;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == 4'd1) begin
               to_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         // Always return to IDLE so a held strobe is not re-sampled here.
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (to_resp) begin
         state_d = S_RESP;
         cnt_d   = 4'd0;
         err_d   = oob;
      end
      wr_en = to_resp & bus.i_wb_we & ~oob;
      rd_en = to_resp & ~bus.i_wb_we & ~oob;
   end

   // FSM state, wait counter and error flag registers.
   always_ff @(posedge i_ck) begin
      if (!i_rb) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Registered read port; holds the last in-range read until the next one.
   always_ff @(posedge i_ck) begin
      if (!i_rb) begin
         dat_q <= '0;
      end else if (rd_en) begin
         dat_q <= mem[idx];
      end
   end

   // Byte-lane write port; memory contents survive reset.
   always_ff @(posedge i_ck) begin
      if (i_rb && wr_en) begin
         for (int n = 0; n < SWIDTH; n++) begin
            if (bus.i_wb_sel[n]) begin
               mem[idx][n*8 +: 8] <= bus.i_wb_dat[n*8 +: 8];
            end
         end
      end
   end

   assign bus.o_wb_dat = dat_q;
   assign bus.o_wb_ack = (state_q == S_RESP) & ~err_q;
   assign bus.o_wb_err = (state_q == S_RESP) & err_q;
endmodule
